// File: rtl/hc74_pkg.sv
// Shared definitions for the 74-series counter models (hc191, hc193, hc161).
//   HC_WIDTH_DEFAULT : datasheet counter width
//   DIR_UP/DIR_DOWN  : encodings of the D_U direction pin
//   tc_detect()      : terminal-count test for a count value in a given direction
package hc74_pkg;

  localparam int   HC_WIDTH_DEFAULT = 4;
  localparam logic DIR_UP           = 1'b0;
  localparam logic DIR_DOWN         = 1'b1;

  // The value is zero-extended into 32 bits so that one function serves every width up to 32.
  // Counting up, terminal count means all ones. Counting down, it means zero.
  function automatic logic tc_detect(input logic [31:0] q, input int width, input logic dir);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (dir == DIR_UP) return (q & mask) == mask;
    else               return (q & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/hc191_updown_counter_if.sv
// Pin bundle of the hc191 counter. clk and reset are not part of it.
//   master : drives LOAD_N, D, CTEN_N, D_U and observes Q, MAX_MIN, RCO_N
//   slave  : the counter side
interface hc191_updown_counter_if
  import hc74_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH_DEFAULT
) ();

  logic             LOAD_N;
  logic [WIDTH-1:0] D;
  logic             CTEN_N;
  logic             D_U;
  logic [WIDTH-1:0] Q;
  logic             MAX_MIN;
  logic             RCO_N;

  modport master (output LOAD_N, D, CTEN_N, D_U, input Q, MAX_MIN, RCO_N);
  modport slave  (input LOAD_N, D, CTEN_N, D_U, output Q, MAX_MIN, RCO_N);

endinterface

// File: rtl/hc191_bit_slice.sv
// One bit of the hc191 counter. This is a JK-style toggle flop with a parallel-load mux.
//   clk, rst_n  : clock and asynchronous active-low reset (the flop is reset to RST_BIT)
//   load        : parallel load takes priority over toggling
//   load_bit    : data bit used by a load
//   toggle_in   : carry in when counting up, borrow in when counting down (already gated by enable)
//   dir         : DIR_UP / DIR_DOWN
//   q           : registered bit
//   toggle_out  : carry/borrow out to the next bit up
module hc191_bit_slice
  import hc74_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_bit,
  input  logic toggle_in,
  input  logic dir,
  output logic q,
  output logic toggle_out
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (load)           q_d = load_bit;
    else if (toggle_in) q_d = ~q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_BIT;
    else        q_q <= q_d;
  end

  // Counting up, a carry passes a bit that is 1. Counting down, a borrow passes a bit that is 0.
  assign toggle_out = toggle_in & ((dir == DIR_DOWN) ? ~q_q : q_q);
  assign q          = q_q;

endmodule

// File: rtl/hc191_updown_counter.sv
// Synchronous presettable up/down binary counter modelled on the 74HC191, with an asynchronous clear.
//   Clk  : rising-edge clock
//   R_N  : asynchronous active-low reset, which sets Q to RST_VAL
//   bus  : LOAD_N, D, CTEN_N, D_U in; Q, MAX_MIN, RCO_N out
module hc191_updown_counter
  import hc74_pkg::*;
#(
  parameter int               WIDTH   = HC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   Clk,
  input  logic                   R_N,
  hc191_updown_counter_if.slave  bus
);

  logic             load;
  logic             count_en;
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] q;
  logic             max_min;

  assign load     = ~bus.LOAD_N;
  assign count_en = ~bus.CTEN_N;
  // Load beats count because each slice's load mux overrides toggle_in.
  assign chain[0] = count_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    hc191_bit_slice #(
      .RST_BIT (RST_VAL[i])
    ) u_slice (
      .clk        (Clk),
      .rst_n      (R_N),
      .load       (load),
      .load_bit   (bus.D[i]),
      .toggle_in  (chain[i]),
      .dir        (bus.D_U),
      .q          (q[i]),
      .toggle_out (chain[i+1])
    );
  end

  assign max_min = tc_detect(32'(q), WIDTH, bus.D_U);

  // The carry out of the top bit is exactly "terminal count and enabled".
  // Gating it with the low phase of Clk makes RCO_N pulse low in the half-period before the wrap edge.
  assign bus.Q       = q;
  assign bus.MAX_MIN = max_min;
  assign bus.RCO_N   = ~(chain[WIDTH] & ~Clk);

endmodule
